// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and mask helper for the 4-to-2 sequential encoder.
// Optional feature macro: ENCODER_ROUND_ROBIN_EN (round-robin selection instead of fixed priority).
package encoder_pkg;

  localparam int N_LINES = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // One-hot mask selecting a single request line by its index.
  function automatic logic [N_LINES-1:0] line_mask(input logic [CODE_W-1:0] idx);
    line_mask = {{(N_LINES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/encoder_pick.sv
// Combinational index selection over the pending request lines.
// Default build scans downward from 'pointer' (fixed priority when pointer=3).
// With ENCODER_ROUND_ROBIN_EN defined it scans upward from 'pointer', wrapping 3->0.
module encoder_pick
  import encoder_pkg::*;
(
  input  logic [N_LINES-1:0] pending,
  input  logic [CODE_W-1:0]  pointer,
  output logic [CODE_W-1:0]  index,
  output logic               found
);

  logic [CODE_W-1:0] pos_s;

  // Walk the lines from the start position and take the first pending one.
  always_comb begin
    found = 1'b0;
    index = {CODE_W{1'b0}};
    pos_s = {CODE_W{1'b0}};
    for (int k = 0; k < N_LINES; k++) begin
`ifdef ENCODER_ROUND_ROBIN_EN
      pos_s = pointer + k[CODE_W-1:0];
`else
      pos_s = pointer - k[CODE_W-1:0];
`endif
      if (!found && pending[pos_s]) begin
        found = 1'b1;
        index = pos_s;
      end else begin
        found = found;
        index = index;
      end
    end
  end

endmodule

// File: rtl/encoder4_2_seq.sv
// Sequential 4-to-2 encoder: captures request lines into Pending and hands out
// one granted index per cycle through a Valid/Ready output stage.
// Optional feature macro: ENCODER_ROUND_ROBIN_EN (round-robin pick with pointer register).
module encoder4_2_seq
  import encoder_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               En,
  input  logic [N_LINES-1:0] Y,
  output logic [CODE_W-1:0]  W,
  output logic               Valid,
  input  logic               Ready,
  output logic [N_LINES-1:0] Pending,
  output logic               Busy
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [N_LINES-1:0] pending_r;
  logic [N_LINES-1:0] pending_nxt_s;
  logic [CODE_W-1:0]  w_r;
  logic [CODE_W-1:0]  w_nxt_s;
  logic               valid_r;
  logic               valid_nxt_s;
  logic               grant_s;
  logic [CODE_W-1:0]  pick_idx_s;
  logic               pick_found_s;
  logic [CODE_W-1:0]  start_s;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [CODE_W-1:0]  ptr_r;
  logic [CODE_W-1:0]  ptr_nxt_s;
  assign start_s = ptr_r;
`else
  // Scanning downward from the top line gives y3 > y2 > y1 > y0.
  localparam logic [CODE_W-1:0] FIXED_START = 2'd3;
  assign start_s = FIXED_START;
`endif

  encoder_pick u_pick (
    .pending (pending_r),
    .pointer (start_s),
    .index   (pick_idx_s),
    .found   (pick_found_s)
  );

  // State register: FSM, captured requests and the registered output stage.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r   <= EMPTY;
      pending_r <= 4'b0000;
      w_r       <= 2'd0;
      valid_r   <= 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
      ptr_r     <= 2'd0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      w_r       <= w_nxt_s;
      valid_r   <= valid_nxt_s;
`ifdef ENCODER_ROUND_ROBIN_EN
      ptr_r     <= ptr_nxt_s;
`endif
    end
  end

  // Next-state logic: decide whether a grant happens and update Pending (set wins over clear).
  always_comb begin
    grant_s       = 1'b0;
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    case (state_r)
      EMPTY: begin
        grant_s     = pick_found_s;
        state_nxt_s = pick_found_s ? HOLD : EMPTY;
      end
      HOLD: begin
        if (Ready) begin
          grant_s     = pick_found_s;
          state_nxt_s = pick_found_s ? HOLD : EMPTY;
        end else begin
          grant_s     = 1'b0;
          state_nxt_s = HOLD;
        end
      end
      default: begin
        grant_s     = 1'b0;
        state_nxt_s = EMPTY;
      end
    endcase
    if (grant_s) begin
      pending_nxt_s = pending_r & ~line_mask(pick_idx_s);
    end else begin
      pending_nxt_s = pending_r;
    end
    if (En) begin
      pending_nxt_s = pending_nxt_s | Y;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

`ifdef ENCODER_ROUND_ROBIN_EN
  // Round-robin pointer: next search starts just above the line granted last.
  always_comb begin
    if (grant_s) begin
      ptr_nxt_s = pick_idx_s + 2'd1;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end
`endif

  // Output logic: next W/Valid, W forced to zero whenever nothing is held.
  always_comb begin
    valid_nxt_s = (state_nxt_s == HOLD);
    if (grant_s) begin
      w_nxt_s = pick_idx_s;
    end else if (state_nxt_s == EMPTY) begin
      w_nxt_s = 2'd0;
    end else begin
      w_nxt_s = w_r;
    end
  end

  assign W       = w_r;
  assign Valid   = valid_r;
  assign Pending = pending_r;
  assign Busy    = (|pending_r) | valid_r;

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Scoreboard bench for encoder4_2_seq: stimulus pushes expected codes,
// a negedge monitor pops and compares on every Valid&Ready transfer.
module tb_encoder4_2_seq;

  logic       Clock;
  logic       Reset;
  logic       En;
  logic [3:0] Y;
  logic [1:0] W;
  logic       Valid;
  logic       Ready;
  logic [3:0] Pending;
  logic       Busy;

  int errors = 0;
  int checks = 0;
  logic [1:0] sb_q[$];

  encoder4_2_seq dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .En      (En),
    .Y       (Y),
    .W       (W),
    .Valid   (Valid),
    .Ready   (Ready),
    .Pending (Pending),
    .Busy    (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, let one rising edge pass, return just after it.
  task automatic drive(input logic en, input logic [3:0] y, input logic rdy);
    En = en; Y = y; Ready = rdy;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    En = 1'b0; Y = 4'b0000; Ready = 1'b0;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(posedge Clock);
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected grants never seen, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: compare each transferred code against the scoreboard; W must be 0 when idle.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (Valid && Ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got W=%0d with no grant expected at %0t", W, $time);
        end else begin
          logic [1:0] exp_w;
          exp_w = sb_q.pop_front();
          if (W !== exp_w) begin
            errors++;
            $display("FAIL grant_code: got W=%0d expected %0d at %0t", W, exp_w, $time);
          end
        end
      end
      if (!Valid) begin
        checks++;
        if (W !== 2'd0) begin
          errors++;
          $display("FAIL idle_w_zero: got W=%0d expected 0 at %0t", W, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; En = 1'b0; Y = 4'b0000; Ready = 1'b0;
    #2;
    chk("reset_w", {2'b00, W}, 4'h0);
    chk("reset_valid", {3'b000, Valid}, 4'h0);
    chk("reset_pending", Pending, 4'h0);
    chk("reset_busy", {3'b000, Busy}, 4'h0);
    do_reset();

    // Single request on y2.
    sb_q.push_back(2'd2);
    drive(1'b1, 4'b0100, 1'b1);
    chk("single_pending", Pending, 4'b0100);
    chk("single_valid_before", {3'b000, Valid}, 4'h0);
    drive(1'b0, 4'b0000, 1'b1);
    chk("single_valid", {3'b000, Valid}, 4'h1);
    chk("single_w", {2'b00, W}, 4'h2);
    drive(1'b0, 4'b0000, 1'b1);
    chk("single_valid_after", {3'b000, Valid}, 4'h0);
    chk("single_busy_after", {3'b000, Busy}, 4'h0);
    drain("single_drain");

    // All four lines at once, grants on consecutive cycles.
    do_reset();
`ifdef ENCODER_ROUND_ROBIN_EN
    sb_q.push_back(2'd0); sb_q.push_back(2'd1); sb_q.push_back(2'd2); sb_q.push_back(2'd3);
`else
    sb_q.push_back(2'd3); sb_q.push_back(2'd2); sb_q.push_back(2'd1); sb_q.push_back(2'd0);
`endif
    drive(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, 1'b1);
      chk("all4_valid_run", {3'b000, Valid}, 4'h1);
    end
    chk("all4_pending_empty", Pending, 4'h0);
    drive(1'b0, 4'b0000, 1'b1);
    chk("all4_valid_end", {3'b000, Valid}, 4'h0);
    drain("all4_drain");

    // Backpressure: grant held stable while Ready=0.
    do_reset();
    sb_q.push_back(2'd1);
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {3'b000, Valid}, 4'h1);
      chk("hold_w", {2'b00, W}, 4'h1);
      chk("hold_pending", Pending, 4'h0);
      drive(1'b0, 4'b0000, 1'b0);
    end
    drive(1'b0, 4'b0000, 1'b1);
    chk("hold_released", {3'b000, Valid}, 4'h0);
    drain("hold_drain");

    // En=0 must ignore Y entirely.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111, 1'b1);
      chk("en0_pending", Pending, 4'h0);
      chk("en0_valid", {3'b000, Valid}, 4'h0);
    end

    // Re-request on the edge that clears the same bit: set wins, second grant follows.
    do_reset();
    sb_q.push_back(2'd0); sb_q.push_back(2'd0);
    drive(1'b1, 4'b0001, 1'b1);
    drive(1'b1, 4'b0001, 1'b1);
    chk("setwin_pending", Pending, 4'b0001);
    chk("setwin_valid", {3'b000, Valid}, 4'h1);
    drive(1'b0, 4'b0000, 1'b1);
    chk("setwin_second_valid", {3'b000, Valid}, 4'h1);
    chk("setwin_pending_clear", Pending, 4'h0);
    drain("setwin_drain");

    // Reset mid-stream with a held grant and requests pending.
    do_reset();
    drive(1'b1, 4'b0100, 1'b0);
    drive(1'b1, 4'b1010, 1'b0);
    chk("mid_valid_pre", {3'b000, Valid}, 4'h1);
    chk("mid_w_pre", {2'b00, W}, 4'h2);
    chk("mid_pending_pre", Pending, 4'b1010);
    En = 1'b0; Y = 4'b0000;
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_w_rst", {2'b00, W}, 4'h0);
    chk("mid_valid_rst", {3'b000, Valid}, 4'h0);
    chk("mid_pending_rst", Pending, 4'h0);
    chk("mid_busy_rst", {3'b000, Busy}, 4'h0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    sb_q.push_back(2'd0);
    drive(1'b1, 4'b0001, 1'b1);
    chk("post_rst_pending", Pending, 4'b0001);
    drive(1'b0, 4'b0000, 1'b1);
    chk("post_rst_valid", {3'b000, Valid}, 4'h1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder4_2_seq.md
ENCODER4_2_SEQ -- requirements
Module: encoder4_2_seq

Interface
REQ-001 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port En  input  1  request-capture enable; Y ignored when 0.
REQ-004 SHALL have port Y  input  4  request lines y3..y0; any number may be high.
REQ-005 SHALL have port W  output  2  encoded index of the granted line.
REQ-006 SHALL have port Valid  output  1  W holds a granted code.
REQ-007 SHALL have port Ready  input  1  consumer accepts W when Valid&Ready.
REQ-008 SHALL have port Pending  output  4  requests captured but not yet granted.
REQ-009 SHALL have port Busy  output  1  (|Pending) | Valid.

Function
REQ-010 SHALL, on each edge with En=1, OR Y into Pending; with En=0 Y SHALL have no effect.
REQ-011 SHALL implement a two-state output FSM: EMPTY (Valid=0) and HOLD (Valid=1).
REQ-012 SHALL, in EMPTY with Pending!=0, pick one index, load W, clear that Pending bit, go to HOLD on the same edge.
REQ-013 SHALL, in HOLD with Ready=1, either load the next pick (stay HOLD) or, if Pending==0, go to EMPTY; one code transferred per cycle maximum.
REQ-014 SHALL hold W and Valid stable in HOLD while Ready=0; Pending keeps accumulating.
REQ-015 SHALL give latency 2 cycles: Y captured at edge n, Valid/W at edge n+1 output earliest, i.e. visible after edge n+1 if FSM was EMPTY.
REQ-016 SHALL, when a new request arrives for the bit being cleared on the same edge, keep that bit set (set wins over clear).
REQ-017 SHALL ignore a repeat request for a line already in Pending (no count, no duplicate grant).
REQ-018 SHALL never assert Valid for an index not previously captured.
REQ-019 SHALL drive W=0 whenever Valid=0.

Reset
REQ-020 SHALL on Reset=1, independent of Clock, force W=0, Valid=0, Pending=0, FSM=EMPTY, round-robin pointer=0.
REQ-021 SHALL discard any in-flight grant and captured requests on reset mid-operation; first capture occurs on first edge after Reset deasserts.

Configuration
REQ-022 SHALL honour macro ENCODER_ROUND_ROBIN_EN.
REQ-023 SHALL, with ENCODER_ROUND_ROBIN_EN defined, pick the first set Pending bit searching upward from (last granted index + 1) mod 4, wrapping 3->0.
REQ-024 SHALL, without ENCODER_ROUND_ROBIN_EN, use fixed priority y3 > y2 > y1 > y0 and contain no pointer register.

Structure
REQ-025 SHALL take constants N_LINES=4, CODE_W=2 and the FSM state type (EMPTY, HOLD) from shared package encoder_pkg.
REQ-026 SHALL place the index selection in combinational sub-module encoder_pick (inputs Pending, pointer; outputs index, found).

Verification
REQ-027 SHALL cover: reset, En=1, Y=4'b0100 for 1 cycle, Ready=1 -> Valid high one cycle with W=2, then Valid=0, Busy=0.
REQ-028 SHALL cover: Y=4'b1111 one cycle, Ready=1 -> fixed mode W=3,2,1,0 on 4 consecutive cycles; round-robin mode W=0,1,2,3 from reset pointer 0.
REQ-029 SHALL cover: Y=4'b0010 with Ready=0 for 5 cycles -> W=1, Valid=1 held stable; Pending=0; grant transfers on first Ready=1 cycle.
REQ-030 SHALL cover: En=0, Y=4'b1111 -> Pending stays 0, Valid stays 0.
REQ-031 SHALL cover: Y=4'b0001 re-asserted on the edge its grant clears it -> Pending[0]=1 afterwards, second W=0 grant follows.
REQ-032 SHALL cover: Reset asserted mid-stream with Valid=1, Pending=4'b1010 -> W=0, Valid=0, Pending=0 immediately, before next Clock edge.
